moore_table_fsm: RTL and testbench
==================================

# moore_table_fsm

Table-driven, parametrised Moore state machine that generalises the team's fixed five-state Moore controllers. It replaces hard-coded case logic with a run-time programmable transition table (NUM_STATES × 2^IN_W entries) and output table (NUM_STATES entries), and adds an enable, a state-change strobe and an optional dwell counter. It sits between input decode logic and downstream consumers, and is configured by a host-side register interface before or during operation.

## Interface
- NUM_STATES, 5, number of legal states (2..16)
- IN_W, 2, width of data_in (1..4)
- OUT_W, 1, width of data_out (1..8)
- DWELL_W, 8, dwell counter width (present only with the config macro)
- ST_W (localparam), $clog2(NUM_STATES), state encoding width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  advance enable; state holds when 0
- data_in  in  IN_W  FSM input symbol
- data_out  out  OUT_W  Moore output, out_tbl[pres_state]
- pres_state  out  ST_W  current state
- state_chg  out  1  one-cycle pulse, state changed on last edge
- cfg_tr_we  in  1  write transition entry
- cfg_out_we  in  1  write output entry
- cfg_state  in  ST_W  table row (source state)
- cfg_in  in  IN_W  input symbol column (transition writes only)
- cfg_next  in  ST_W  next-state value for transition write
- cfg_out  in  OUT_W  output value for output write
- cfg_err  out  1  one-cycle pulse, rejected write
- dwell  out  DWELL_W  cycles spent in current state

## Operation
- Reset is sampled on a rising clock edge when reset==0, and gives: pres_state=0, every tr_tbl[s][i]=s (self-loop), every out_tbl[s]=0, state_chg=0, cfg_err=0, dwell=0. data_out=0 follows from these values.
- Reset has priority over en and over cfg writes in the same cycle.
- Advance: when en==1, pres_state <= tr_tbl[pres_state][data_in]. When en==0, pres_state holds.
- data_out is a combinational decode of registered pres_state and out_tbl. It has no path from data_in.
- Defensive recovery: if pres_state >= NUM_STATES, the next state is 0 regardless of en. This case is unreachable in normal use.
- state_chg is registered. It is 1 for the cycle after any edge where pres_state took a different value.
- Config writes:
  - A write is rejected when cfg_state >= NUM_STATES, or when cfg_tr_we has cfg_next >= NUM_STATES. A rejected write leaves the tables unchanged and pulses cfg_err the next cycle.
  - cfg_tr_we and cfg_out_we may be asserted together. Each is checked independently. An invalid transition write does not block a valid output write to the same row.
- Simultaneous write and use: the state advance on a given edge uses the table contents from before that edge. A new entry first affects the next edge. A write to out_tbl[pres_state] is visible on data_out one cycle after the write edge.

## Timing
- Input-to-state latency is 1 cycle. The state-to-output path is combinational, so data_out is valid in the same cycle pres_state updates.
- state_chg and cfg_err are 1-cycle registered pulses.
- Writes on back-to-back cycles are each accepted. There is no backpressure.
- Reset asserted mid-operation wipes both tables. Software must reprogram them after any reset.

## Configuration
- Macro: MOORE_TABLE_DWELL_EN.
- Defined:
  - dwell counts +1 on each edge where en==1 and the state does not change.
  - dwell clears to 0 on the edge where the state changes, and on reset.
  - dwell saturates at 2^DWELL_W−1.
  - dwell holds when en==0.
- Undefined: the dwell port is still present and tied to 0, and no counter logic is built.

## Test plan
- Reset check: with default parameters, hold reset=0 for 2 cycles, then apply data_in=2'b11 with en=1 for 4 cycles. Required: pres_state=0, data_out=0, state_chg=0 throughout.
- Legacy map: program the following tables.
  - out = {1,0,1,0,1}.
  - st0: 00→0, 01→4, 10→1, 11→2.
  - st1: 00→0, 10→2, others→1.
  - st2: 0x→1, 1x→3.
  - st3: x1→4, others→3.
  - st4: 11→4, others→0.
  - Drive 10, 10, 11, 01, 00. Required states: 1, 2, 3, 4, 0. Required data_out: 0, 1, 0, 1, 1. state_chg is high for 5 consecutive cycles.
- en gating: in st2, set en=0 for 3 cycles with data_in=2'b10. Required: state stays 2, state_chg=0, dwell frozen. Then en=1. Required: state becomes 3 after 1 edge.
- Illegal writes:
  - cfg_state=5 with cfg_tr_we → cfg_err pulses, table unchanged.
  - cfg_next=7 together with a valid cfg_out_we to row 1 → cfg_err pulses and out_tbl[1] is updated.
- Write/use collision: in st0, write tr_tbl[0][2'b10]=3 on the same edge as en=1, data_in=2'b10. Required: the FSM goes to 1 (old entry). The next visit to st0 with input 10 goes to 3.
- Dwell (macro defined, DWELL_W=4): hold a self-loop for 20 cycles. Required: dwell saturates at 15. On the next state change, dwell returns to 0.

Source files
------------

// File: rtl/moore_table_fsm_if.sv
// moore_table_fsm_if: host-side table programming port.
// master = host/config side, slave = the FSM.
interface moore_table_fsm_if #(
  parameter int NUM_STATES = 5,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1
);
  localparam int ST_W = $clog2(NUM_STATES);

  logic             cfg_tr_we;
  logic             cfg_out_we;
  logic [ST_W-1:0]  cfg_state;
  logic [IN_W-1:0]  cfg_in;
  logic [ST_W-1:0]  cfg_next;
  logic [OUT_W-1:0] cfg_out;
  logic             cfg_err;

  modport master (
    output cfg_tr_we,
    output cfg_out_we,
    output cfg_state,
    output cfg_in,
    output cfg_next,
    output cfg_out,
    input  cfg_err
  );

  modport slave (
    input  cfg_tr_we,
    input  cfg_out_we,
    input  cfg_state,
    input  cfg_in,
    input  cfg_next,
    input  cfg_out,
    output cfg_err
  );
endinterface

// File: rtl/moore_table_fsm.sv
// moore_table_fsm: run-time programmable Moore FSM (transition + output tables).
// MOORE_TABLE_DWELL_EN builds the saturating dwell counter; else dwell is 0.
module moore_table_fsm #(
  parameter int NUM_STATES = 5,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 1,
  parameter int DWELL_W    = 8,
  localparam int ST_W      = $clog2(NUM_STATES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [IN_W-1:0]    data_in,
  output logic [OUT_W-1:0]   data_out,
  output logic [ST_W-1:0]    pres_state,
  output logic               state_chg,
  output logic [DWELL_W-1:0] dwell,
  moore_table_fsm_if.slave   cfg
);
  localparam int NIN = 1 << IN_W;

  logic [ST_W-1:0]  tr_tbl  [NUM_STATES][NIN];
  logic [OUT_W-1:0] out_tbl [NUM_STATES];

  logic             pres_ok;
  logic [ST_W-1:0]  nxt;
  logic [OUT_W-1:0] dout_c;
  logic             st_ok;
  logic             nx_ok;
  logic             tr_ok;
  logic             out_ok;
  logic             wr_err;

  // Next state from the pre-edge table; out-of-range state recovers to 0.
  always_comb begin
    pres_ok = int'(pres_state) < NUM_STATES;
    nxt     = pres_state;
    dout_c  = '0;
    if (!pres_ok) begin
      nxt = '0;
    end else begin
      dout_c = out_tbl[pres_state];
      if (en) nxt = tr_tbl[pres_state][data_in];
    end
  end

  assign data_out = dout_c;

  // Config write qualification; tr and out writes are judged separately.
  always_comb begin
    st_ok  = int'(cfg.cfg_state) < NUM_STATES;
    nx_ok  = int'(cfg.cfg_next) < NUM_STATES;
    tr_ok  = cfg.cfg_tr_we && st_ok && nx_ok;
    out_ok = cfg.cfg_out_we && st_ok;
    wr_err = (cfg.cfg_tr_we && !(st_ok && nx_ok)) ||
             (cfg.cfg_out_we && !st_ok);
  end

  // State, strobes, tables and dwell; reset wins over en and writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pres_state  <= '0;
      state_chg   <= 1'b0;
      cfg.cfg_err <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) begin
        out_tbl[s] <= '0;
        for (int i = 0; i < NIN; i++) begin
          tr_tbl[s][i] <= ST_W'(s);
        end
      end
`ifdef MOORE_TABLE_DWELL_EN
      dwell <= '0;
`endif
    end else begin
      pres_state  <= nxt;
      state_chg   <= nxt != pres_state;
      cfg.cfg_err <= wr_err;
      if (tr_ok) begin
        tr_tbl[cfg.cfg_state][cfg.cfg_in] <= cfg.cfg_next;
      end
      if (out_ok) begin
        out_tbl[cfg.cfg_state] <= cfg.cfg_out;
      end
`ifdef MOORE_TABLE_DWELL_EN
      if (nxt != pres_state) begin
        dwell <= '0;
      end else if (en && dwell != '1) begin
        dwell <= dwell + DWELL_W'(1);
      end
`endif
    end
  end

`ifndef MOORE_TABLE_DWELL_EN
  assign dwell = '0;
`endif

endmodule

// File: tb/tb_moore_table_fsm.sv
// tb_moore_table_fsm: directed vectors with a queue scoreboard.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_moore_table_fsm;
  localparam int DW     = 4;
  localparam int DW_MAX = (1 << DW) - 1;

  logic         clock;
  logic         reset;
  logic         en;
  logic [1:0]   data_in;
  logic [0:0]   data_out;
  logic [2:0]   pres_state;
  logic         state_chg;
  logic [DW-1:0] dwell;

  moore_table_fsm_if #(
    .NUM_STATES(5), .IN_W(2), .OUT_W(1)
  ) cfg_if ();

  moore_table_fsm #(
    .NUM_STATES(5), .IN_W(2), .OUT_W(1), .DWELL_W(DW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .data_in(data_in),
    .data_out(data_out),
    .pres_state(pres_state),
    .state_chg(state_chg),
    .dwell(dwell),
    .cfg(cfg_if.slave)
  );

  typedef struct {
    int    cyc;
    int    st;
    int    dout;
    int    chg;
    int    err;
    int    dw;
    string nm;
  } exp_t;

  exp_t  sb[$];
  exp_t  e;
  int    ncyc   = 0;
  int    checks = 0;
  int    errors = 0;
  int    m_dw   = 0;
  logic  rst_v  = 1'b0;

  int tr_map [5][4] = '{
    '{0, 4, 1, 2},
    '{0, 1, 2, 1},
    '{1, 1, 3, 3},
    '{3, 4, 3, 4},
    '{0, 0, 0, 4}
  };
  int out_v [5] = '{1, 0, 1, 0, 1};
  int out_order [5] = '{1, 2, 3, 4, 0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(string nm, string f, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
    end
  endfunction

  // Monitor: compare every expectation due on this negedge.
  always @(negedge clock) begin
    ncyc = ncyc + 1;
    while (sb.size() > 0 && sb[0].cyc == ncyc) begin
      e = sb.pop_front();
      chk(e.nm, "state", int'(pres_state), e.st);
      chk(e.nm, "data_out", int'(data_out), e.dout);
      chk(e.nm, "state_chg", int'(state_chg), e.chg);
      chk(e.nm, "cfg_err", int'(cfg_if.cfg_err), e.err);
      chk(e.nm, "dwell", int'(dwell), e.dw);
    end
  end

  task automatic step(
    input logic e_in, input int d,
    input logic tw, input logic ow,
    input int cs, input int ci, input int cn, input int co,
    input int xs, input int xo, input int xc, input int xe,
    input string nm
  );
    exp_t x;
    @(posedge clock);
    #1;
    reset             = rst_v;
    en                = e_in;
    data_in           = 2'(d);
    cfg_if.cfg_tr_we  = tw;
    cfg_if.cfg_out_we = ow;
    cfg_if.cfg_state  = 3'(cs);
    cfg_if.cfg_in     = 2'(ci);
    cfg_if.cfg_next   = 3'(cn);
    cfg_if.cfg_out    = 1'(co);
    if (!rst_v) m_dw = 0;
    else if (xc != 0) m_dw = 0;
    else if (e_in && m_dw < DW_MAX) m_dw++;
    x.cyc  = ncyc + 2;
    x.st   = xs;
    x.dout = xo;
    x.chg  = xc;
    x.err  = xe;
`ifdef MOORE_TABLE_DWELL_EN
    x.dw   = m_dw;
`else
    x.dw   = 0;
`endif
    x.nm   = nm;
    sb.push_back(x);
  endtask

  task automatic run(input int d, input int xs, input int xo,
                     input int xc, input string nm);
    step(1'b1, d, 1'b0, 1'b0, 0, 0, 0, 0, xs, xo, xc, 0, nm);
  endtask

  task automatic hold(input int d, input int xs, input int xo,
                      input string nm);
    step(1'b0, d, 1'b0, 1'b0, 0, 0, 0, 0, xs, xo, 0, 0, nm);
  endtask

  task automatic wr(input logic tw, input logic ow,
                    input int cs, input int ci, input int cn, input int co,
                    input int xs, input int xo, input int xe,
                    input string nm);
    step(1'b0, 0, tw, ow, cs, ci, cn, co, xs, xo, 0, xe, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b0;
    en                = 1'b0;
    data_in           = '0;
    cfg_if.cfg_tr_we  = 1'b0;
    cfg_if.cfg_out_we = 1'b0;
    cfg_if.cfg_state  = '0;
    cfg_if.cfg_in     = '0;
    cfg_if.cfg_next   = '0;
    cfg_if.cfg_out    = '0;

    rst_v = 1'b0;
    repeat (2) run(3, 0, 0, 0, "reset");
    rst_v = 1'b1;
    repeat (4) run(3, 0, 0, 0, "reset_selfloop");

    for (int s = 0; s < 5; s++)
      for (int i = 0; i < 4; i++)
        wr(1'b1, 1'b0, s, i, tr_map[s][i], 0, 0, 0, 0, "prog_tr");
    for (int k = 0; k < 5; k++)
      wr(1'b0, 1'b1, out_order[k], 0, 0, out_v[out_order[k]],
         0, (out_order[k] == 0) ? 1 : 0, 0, "prog_out");
    hold(0, 0, 1, "out0_visible");

    run(2, 1, 0, 1, "legacy_1");
    run(2, 2, 1, 1, "legacy_2");
    run(3, 3, 0, 1, "legacy_3");
    run(1, 4, 1, 1, "legacy_4");
    run(0, 0, 1, 1, "legacy_0");

    run(2, 1, 0, 1, "to_st1");
    run(2, 2, 1, 1, "to_st2");
    repeat (3) hold(2, 2, 1, "en_gate");
    run(2, 3, 0, 1, "en_release");

    wr(1'b1, 1'b0, 5, 0, 0, 0, 3, 0, 1, "bad_row");
    wr(1'b1, 1'b1, 1, 0, 7, 1, 3, 0, 1, "bad_next_out_ok");
    run(1, 4, 1, 1, "after_bad_4");
    run(0, 0, 1, 1, "after_bad_0");
    run(2, 1, 1, 1, "out1_updated");
    run(0, 0, 1, 1, "tr1_unchanged");
    wr(1'b0, 1'b1, 5, 0, 0, 1, 0, 1, 1, "bad_out_row");

    step(1'b1, 2, 1'b1, 1'b0, 0, 2, 3, 0, 1, 1, 1, 0, "collide_old");
    run(0, 0, 1, 1, "collide_back");
    run(2, 3, 0, 1, "collide_new");

    repeat (20) run(0, 3, 0, 0, "dwell_hold");
    run(1, 4, 1, 1, "dwell_clear");

    rst_v = 1'b0;
    run(1, 0, 0, 0, "mid_reset");
    rst_v = 1'b1;
    run(1, 0, 0, 0, "tables_wiped");

    repeat (4) @(posedge clock);
    #1;
    chk("scoreboard", "drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
